// File: rtl/mini_cpu_pkg.sv
// Shared opcodes, FSM state type and instruction-width helper for the mini CPU core.
package mini_cpu_pkg;

    localparam logic [2:0] OP_LOAD    = 3'd0;
    localparam logic [2:0] OP_ADD     = 3'd1;
    localparam logic [2:0] OP_ADDI    = 3'd2;
    localparam logic [2:0] OP_SUB     = 3'd3;
    localparam logic [2:0] OP_SUBI    = 3'd4;
    localparam logic [2:0] OP_MUL     = 3'd5;
    localparam logic [2:0] OP_CLEAR   = 3'd6;
    localparam logic [2:0] OP_DISPLAY = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_EXEC,
        S_MULT,
        S_WRITE,
        S_DISP
    } state_e;

    function automatic int instr_width(input int reg_aw, input int imm_w);
        return 3 + 2 * reg_aw + imm_w + 1;
    endfunction

endpackage

// File: rtl/mini_cpu_core_if.sv
// Instruction-issue and display channel between the switch front end, the core and the LCD controller.
interface mini_cpu_core_if #(
    parameter int DATA_W  = 16,
    parameter int REG_AW  = 4,
    parameter int INSTR_W = 18
);
    logic [INSTR_W-1:0] instr;
    logic               go;
    logic               busy;
    logic               disp_valid;
    logic               disp_ready;
    logic [2:0]         disp_opcode;
    logic [REG_AW-1:0]  disp_reg_idx;
    logic [DATA_W-1:0]  disp_value;
    logic               flag_zero;
    logic               flag_ovf;

    modport master (
        output instr, go, disp_ready,
        input  busy, disp_valid, disp_opcode, disp_reg_idx, disp_value, flag_zero, flag_ovf
    );

    modport slave (
        input  instr, go, disp_ready,
        output busy, disp_valid, disp_opcode, disp_reg_idx, disp_value, flag_zero, flag_ovf
    );
endinterface

// File: rtl/cpu_regfile.sv
// NREGS x DATA_W register file: two async read ports, one sync write port, sync clear-all.
module cpu_regfile #(
    parameter int DATA_W = 16,
    parameter int NREGS  = 16,
    parameter int REG_AW = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] ra_i,
    input  logic [REG_AW-1:0] rb_i,
    output logic [DATA_W-1:0] ra_data_o,
    output logic [DATA_W-1:0] rb_data_o,
    input  logic              we_i,
    input  logic [REG_AW-1:0] wa_i,
    input  logic [DATA_W-1:0] wd_i,
    input  logic              clr_i
);
    logic [DATA_W-1:0] regs_q [NREGS];

    always_ff @(posedge clk) begin
        if (reset || clr_i) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else if (we_i) begin
            regs_q[wa_i] <= wd_i;
        end
    end

    assign ra_data_o = regs_q[ra_i];
    assign rb_data_o = regs_q[rb_i];
endmodule

// File: rtl/mini_cpu_core.sv
// Mini CPU: IDLE(wait go) > DECODE(read operands) > EXEC(alu / mul setup) > MULT(shift-add)
// > WRITE(commit regs, flags, record) > DISP(hold record until disp_ready).
module mini_cpu_core
    import mini_cpu_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int NREGS   = 16,
    parameter int REG_AW  = $clog2(NREGS),
    parameter int IMM_W   = 6,
    parameter int INSTR_W = instr_width(REG_AW, IMM_W)
) (
    input logic            clk,
    input logic            reset,
    mini_cpu_core_if.slave bus
);
    localparam int MSB   = DATA_W - 1;
    localparam int P_W   = DATA_W + IMM_W;
    localparam int CNT_W = $clog2(IMM_W + 1);

    state_e             state_q, state_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [DATA_W-1:0]  a_q, a_d, b_q, b_d, res_q, res_d;
    logic               zero_n_q, zero_n_d, ovf_n_q, ovf_n_d;
    logic [P_W-1:0]     mcand_q, mcand_d, acc_q, acc_d;
    logic [IMM_W-1:0]   mplier_q, mplier_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               flag_zero_q, flag_zero_d, flag_ovf_q, flag_ovf_d;
    logic [2:0]         disp_op_q, disp_op_d;
    logic [REG_AW-1:0]  disp_idx_q, disp_idx_d;
    logic [DATA_W-1:0]  disp_val_q, disp_val_d;

    logic [2:0]         op;
    logic [REG_AW-1:0]  rd, rs1, rs2;
    logic               sgn;
    logic [IMM_W-1:0]   mag;
    logic [DATA_W-1:0]  mag_ext, imm, opnd, ra_data, rb_data, rf_wd;
    logic [P_W-1:0]     prod;
    logic               mul_ovf, rf_we, rf_clr;

    assign op      = instr_q[INSTR_W-1 -: 3];
    assign rd      = instr_q[IMM_W+1+REG_AW +: REG_AW];
    assign rs1     = instr_q[IMM_W+1 +: REG_AW];
    assign rs2     = instr_q[IMM_W -: REG_AW];
    assign sgn     = instr_q[IMM_W];
    assign mag     = instr_q[IMM_W-1:0];
    assign mag_ext = DATA_W'(mag);
    assign imm     = sgn ? (~mag_ext + DATA_W'(1)) : mag_ext;
    assign opnd    = (op == OP_ADD || op == OP_SUB) ? b_q : imm;

    // Product is accumulated on |imm|; sign is applied once the magnitude is complete.
    assign prod    = sgn ? (~acc_q + P_W'(1)) : acc_q;
    assign mul_ovf = !((&prod[P_W-1:MSB]) || !(|prod[P_W-1:MSB]));

    cpu_regfile #(.DATA_W(DATA_W), .NREGS(NREGS), .REG_AW(REG_AW)) u_regfile (
        .clk       (clk),
        .reset     (reset),
        .ra_i      (rs1),
        .rb_i      (rs2),
        .ra_data_o (ra_data),
        .rb_data_o (rb_data),
        .we_i      (rf_we),
        .wa_i      (rd),
        .wd_i      (rf_wd),
        .clr_i     (rf_clr)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            instr_q     <= '0;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            zero_n_q    <= 1'b0;
            ovf_n_q     <= 1'b0;
            mcand_q     <= '0;
            acc_q       <= '0;
            mplier_q    <= '0;
            cnt_q       <= '0;
            flag_zero_q <= 1'b0;
            flag_ovf_q  <= 1'b0;
            disp_op_q   <= '0;
            disp_idx_q  <= '0;
            disp_val_q  <= '0;
        end else begin
            state_q     <= state_d;
            instr_q     <= instr_d;
            a_q         <= a_d;
            b_q         <= b_d;
            res_q       <= res_d;
            zero_n_q    <= zero_n_d;
            ovf_n_q     <= ovf_n_d;
            mcand_q     <= mcand_d;
            acc_q       <= acc_d;
            mplier_q    <= mplier_d;
            cnt_q       <= cnt_d;
            flag_zero_q <= flag_zero_d;
            flag_ovf_q  <= flag_ovf_d;
            disp_op_q   <= disp_op_d;
            disp_idx_q  <= disp_idx_d;
            disp_val_q  <= disp_val_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        instr_d     = instr_q;
        a_d         = a_q;
        b_d         = b_q;
        res_d       = res_q;
        zero_n_d    = zero_n_q;
        ovf_n_d     = ovf_n_q;
        mcand_d     = mcand_q;
        acc_d       = acc_q;
        mplier_d    = mplier_q;
        cnt_d       = cnt_q;
        flag_zero_d = flag_zero_q;
        flag_ovf_d  = flag_ovf_q;
        disp_op_d   = disp_op_q;
        disp_idx_d  = disp_idx_q;
        disp_val_d  = disp_val_q;
        rf_we       = 1'b0;
        rf_clr      = 1'b0;
        rf_wd       = res_q;

        case (state_q)
            S_IDLE: begin
                if (bus.go) begin
                    instr_d = bus.instr;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                a_d     = ra_data;
                b_d     = rb_data;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                state_d = S_WRITE;
                ovf_n_d = 1'b0;
                case (op)
                    OP_LOAD: res_d = imm;
                    OP_ADD, OP_ADDI: begin
                        res_d   = a_q + opnd;
                        ovf_n_d = (a_q[MSB] == opnd[MSB]) && (res_d[MSB] != a_q[MSB]);
                    end
                    OP_SUB, OP_SUBI: begin
                        res_d   = a_q - opnd;
                        ovf_n_d = (a_q[MSB] != opnd[MSB]) && (res_d[MSB] != a_q[MSB]);
                    end
                    OP_MUL: begin
                        mcand_d  = {{IMM_W{a_q[MSB]}}, a_q};
                        mplier_d = mag;
                        acc_d    = '0;
                        cnt_d    = CNT_W'(IMM_W - 1);
                        state_d  = S_MULT;
                    end
                    OP_CLEAR: res_d = '0;
                    default:  res_d = a_q;
                endcase
                zero_n_d = (res_d == '0);
            end
            S_MULT: begin
                if (mplier_q[0]) acc_d = acc_q + mcand_q;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                if (cnt_q == '0) state_d = S_WRITE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            S_WRITE: begin
                state_d    = S_DISP;
                disp_op_d  = op;
                disp_idx_d = rd;
                case (op)
                    OP_CLEAR: begin
                        rf_clr      = 1'b1;
                        flag_zero_d = 1'b0;
                        flag_ovf_d  = 1'b0;
                        disp_val_d  = '0;
                    end
                    OP_DISPLAY: begin
                        disp_idx_d = rs1;
                        disp_val_d = a_q;
                    end
                    OP_MUL: begin
                        rf_we       = 1'b1;
                        rf_wd       = prod[MSB:0];
                        flag_zero_d = (prod[MSB:0] == '0);
                        flag_ovf_d  = mul_ovf;
                        disp_val_d  = prod[MSB:0];
                    end
                    default: begin
                        rf_we       = 1'b1;
                        flag_zero_d = zero_n_q;
                        flag_ovf_d  = ovf_n_q;
                        disp_val_d  = res_q;
                    end
                endcase
            end
            S_DISP: begin
                if (bus.disp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.busy         = (state_q != S_IDLE);
    assign bus.disp_valid   = (state_q == S_DISP);
    assign bus.disp_opcode  = disp_op_q;
    assign bus.disp_reg_idx = disp_idx_q;
    assign bus.disp_value   = disp_val_q;
    assign bus.flag_zero    = flag_zero_q;
    assign bus.flag_ovf     = flag_ovf_q;
endmodule
